// File: rtl/tx_pkg.sv
// Shared transmit-side definitions: PRBS9 taps/seeds, symbol encoding and
// the saturate/align helper also used by the receive blocks.
package tx_pkg;

  localparam int PRBS_LEN     = 9;
  localparam int PRBS_TAP_OUT = 8;  // output bit and first feedback tap
  localparam int PRBS_TAP_FB  = 4;  // second feedback tap (x^5 term)

  localparam logic [PRBS_LEN-1:0] SEED_I_DEF = 9'h1AA;
  localparam logic [PRBS_LEN-1:0] SEED_Q_DEF = 9'h1FE;

  // Symbol entry {nz, neg}: +1, -1 or an empty slot.
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b10;
  localparam logic [1:0] SYM_NEG  = 2'b11;

  // Align by 'shift' fractional bits (arithmetic right shift truncates,
  // negative shift scales up), then clamp to an nbt-bit signed range.
  function automatic logic signed [31:0] sat_trunc(input logic signed [31:0] x,
                                                   input int shift,
                                                   input int nbt);
    logic signed [31:0] y;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    if (shift >= 0) y = x >>> shift;
    else            y = x <<< (-shift);
    hi = (32'sd1 <<< (nbt - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (nbt - 1));
    if (y > hi)      r = hi;
    else if (y < lo) r = lo;
    else             r = y;
    return r;
  endfunction

endpackage

// File: rtl/tx_qpsk_shaper_prbs9.sv
// PRBS9 generator, x^9 + x^5 + 1, one bit per enabled cycle.
module prbs9_gen
  import tx_pkg::*;
#(
  parameter logic [PRBS_LEN-1:0] SEED = SEED_I_DEF
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_bit
);

  logic [PRBS_LEN-1:0] s_q;
  logic [PRBS_LEN-1:0] s_d;

  // Shift left and insert feedback only when enabled; otherwise hold.
  always_comb begin
    s_d = s_q;
    if (i_en) s_d = {s_q[PRBS_LEN-2:0], s_q[PRBS_TAP_OUT] ^ s_q[PRBS_TAP_FB]};
  end

  // State register, reloads the seed on reset.
  always_ff @(posedge clk) begin
    if (i_reset) s_q <= SEED;
    else         s_q <= s_d;
  end

  assign o_bit = s_q[PRBS_TAP_OUT];

endmodule

// File: rtl/tx_qpsk_shaper.sv
// QPSK test source: PRBS9 I/Q symbols, OS-times upsampled through a
// fixed polyphase pulse-shaping FIR, saturated at the sample rate.
module tx_qpsk_shaper
  import tx_pkg::*;
#(
  parameter int OS       = 2,
  parameter int NUM_TAPS = 12,
  parameter int NBT_COEF = 8,
  parameter int NBF_COEF = 7,
  parameter logic [NUM_TAPS*NBT_COEF-1:0] COEFS =
    {8'hFE, 8'hFB, 8'h00, 8'd19, 8'd51, 8'd76, 8'd76, 8'd51, 8'd19, 8'h00, 8'hFB, 8'hFE},
  parameter int NBT_OUT  = 8,
  parameter int NBF_OUT  = 7,
  parameter logic [PRBS_LEN-1:0] SEED_I = SEED_I_DEF,
  parameter logic [PRBS_LEN-1:0] SEED_Q = SEED_Q_DEF
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_en_rate1,
  input  logic                      i_en_rate2,
  input  logic                      i_enable_tx,
  output logic signed [NBT_OUT-1:0] o_os_data_I,
  output logic signed [NBT_OUT-1:0] o_os_data_Q,
  output logic                      o_sym_I,
  output logic                      o_sym_Q,
  output logic                      o_valid
);

  localparam int NSYM  = NUM_TAPS / OS;
  localparam int ACC_W = NBT_COEF + $clog2(NSYM) + 1;
  localparam int PH_W  = (OS > 1) ? $clog2(OS) : 1;
  localparam int SHIFT = NBF_COEF - NBF_OUT;

  logic advance;
  logic bit_i, bit_q;
  logic [1:0] new_i, new_q;

  logic [NSYM-1:0][1:0] sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic signed [NBT_OUT-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic sym_bit_i_q, sym_bit_i_d, sym_bit_q_q, sym_bit_q_d;
  logic valid_q, valid_d;

  logic signed [NBT_COEF-1:0] coef_tab [NUM_TAPS];
  logic signed [NBT_COEF-1:0] coef_sel;
  logic signed [ACC_W-1:0]    acc_i, acc_q;

  // PRBS only moves on symbols that are actually transmitted.
  assign advance = i_en_rate1 & i_enable_tx;

  prbs9_gen #(.SEED(SEED_I)) u_prbs_i (.clk(clk), .i_reset(i_reset), .i_en(advance), .o_bit(bit_i));
  prbs9_gen #(.SEED(SEED_Q)) u_prbs_q (.clk(clk), .i_reset(i_reset), .i_en(advance), .o_bit(bit_q));

  // Bit 0 maps to +1, bit 1 to -1; flushing injects empty slots.
  assign new_i = i_enable_tx ? (bit_i ? SYM_NEG : SYM_POS) : SYM_ZERO;
  assign new_q = i_enable_tx ? (bit_q ? SYM_NEG : SYM_POS) : SYM_ZERO;

  // Unpack the coefficient vector, h[0] in the least significant slot.
  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_coef
    assign coef_tab[g] = COEFS[g*NBT_COEF +: NBT_COEF];
  end

  // Symbol shift, reference bits and phase counter next-state.
  always_comb begin
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    sym_bit_i_d = sym_bit_i_q;
    sym_bit_q_d = sym_bit_q_q;
    phase_d     = phase_q;
    if (i_en_rate1) begin
      for (int k = NSYM - 1; k > 0; k--) begin
        sym_i_d[k] = sym_i_q[k-1];
        sym_q_d[k] = sym_q_q[k-1];
      end
      sym_i_d[0] = new_i;
      sym_q_d[0] = new_q;
      if (i_enable_tx) begin
        sym_bit_i_d = bit_i;
        sym_bit_q_d = bit_q;
      end
    end
    if (i_en_rate2) begin
      if (i_en_rate1 || (phase_q == PH_W'(OS - 1))) phase_d = '0;
      else                                          phase_d = phase_q + 1'b1;
    end
  end

  // Polyphase FIR: each slot adds, subtracts or skips its phase coefficient.
  always_comb begin
    acc_i    = '0;
    acc_q    = '0;
    coef_sel = '0;
    for (int k = 0; k < NSYM; k++) begin
      coef_sel = '0;
      for (int p = 0; p < OS; p++) begin
        if (phase_q == PH_W'(p)) coef_sel = coef_tab[k*OS + p];
      end
      if (sym_i_q[k][1]) acc_i = sym_i_q[k][0] ? acc_i - ACC_W'(coef_sel) : acc_i + ACC_W'(coef_sel);
      if (sym_q_q[k][1]) acc_q = sym_q_q[k][0] ? acc_q - ACC_W'(coef_sel) : acc_q + ACC_W'(coef_sel);
    end
  end

  // Output samples update on sample-rate enables only; valid marks them.
  always_comb begin
    out_i_d = out_i_q;
    out_q_d = out_q_q;
    valid_d = 1'b0;
    if (i_en_rate2) begin
      out_i_d = NBT_OUT'(sat_trunc(32'(acc_i), SHIFT, NBT_OUT));
      out_q_d = NBT_OUT'(sat_trunc(32'(acc_q), SHIFT, NBT_OUT));
      valid_d = 1'b1;
    end
  end

  // State registers; reset wins over every enable.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      sym_bit_i_q <= 1'b0;
      sym_bit_q_q <= 1'b0;
      phase_q     <= '0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      sym_bit_i_q <= sym_bit_i_d;
      sym_bit_q_q <= sym_bit_q_d;
      phase_q     <= phase_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      valid_q     <= valid_d;
    end
  end

  // A symbol enable must land on a sample enable.
  always @(posedge clk) begin
    if (!i_reset) assert (!(i_en_rate1 && !i_en_rate2));
  end

  assign o_os_data_I = out_i_q;
  assign o_os_data_Q = out_q_q;
  assign o_sym_I     = sym_bit_i_q;
  assign o_sym_Q     = sym_bit_q_q;
  assign o_valid     = valid_q;

endmodule

// File: tb/tb_tx_qpsk_shaper.sv
// Directed bench for tx_qpsk_shaper: reset, PRBS order, impulse response,
// saturation, mid-symbol reset, flush/resume and a long reference run.
module tb_tx_qpsk_shaper;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_reset = 1'b1;
  logic i_en_rate1 = 1'b0;
  logic i_en_rate2 = 1'b0;
  logic i_enable_tx = 1'b0;

  logic signed [7:0] o_os_data_I, o_os_data_Q;
  logic o_sym_I, o_sym_Q, o_valid;
  logic signed [7:0] sp_I, sp_Q, sn_I, sn_Q;
  logic sp_sym_I, sp_sym_Q, sp_valid, sn_sym_I, sn_sym_Q, sn_valid;

  tx_qpsk_shaper dut (
    .clk(clk), .i_reset(i_reset), .i_en_rate1(i_en_rate1), .i_en_rate2(i_en_rate2),
    .i_enable_tx(i_enable_tx), .o_os_data_I(o_os_data_I), .o_os_data_Q(o_os_data_Q),
    .o_sym_I(o_sym_I), .o_sym_Q(o_sym_Q), .o_valid(o_valid)
  );

  // Zero seeds keep the PRBS at 0, i.e. every symbol is +1.
  tx_qpsk_shaper #(.COEFS({12{8'd127}}), .SEED_I(9'h000), .SEED_Q(9'h000)) dut_sat_pos (
    .clk(clk), .i_reset(i_reset), .i_en_rate1(i_en_rate1), .i_en_rate2(i_en_rate2),
    .i_enable_tx(i_enable_tx), .o_os_data_I(sp_I), .o_os_data_Q(sp_Q),
    .o_sym_I(sp_sym_I), .o_sym_Q(sp_sym_Q), .o_valid(sp_valid)
  );

  // Same all-+1 symbols against -127 coefficients: the all -1 product.
  tx_qpsk_shaper #(.COEFS({12{8'h81}}), .SEED_I(9'h000), .SEED_Q(9'h000)) dut_sat_neg (
    .clk(clk), .i_reset(i_reset), .i_en_rate1(i_en_rate1), .i_en_rate2(i_en_rate2),
    .i_enable_tx(i_enable_tx), .o_os_data_I(sn_I), .o_os_data_Q(sn_Q),
    .o_sym_I(sn_sym_I), .o_sym_Q(sn_sym_Q), .o_valid(sn_valid)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int rate2_cnt = 0;
  int valid_cnt = 0;
  bit sb_on = 1'b0;
  logic signed [7:0] exp_q[$];

  int h[12]      = '{-2, -5, 0, 19, 51, 76, 76, 51, 19, 0, -5, -2};
  int seq_i[9]   = '{1, 1, 0, 1, 0, 1, 0, 1, 0};  // first bits from 9'h1AA
  int seq_q[9]   = '{1, 1, 1, 1, 1, 1, 1, 1, 0};  // first bits from 9'h1FE
  int resume_i[4] = '{1, 0, 0, 0};                // bits 9..12 of the I stream
  int impulse[12] = '{2, 5, 0, -19, -51, -76, -76, -51, -19, 0, 5, 2};

  // Reference model state.
  logic [8:0] m_pi, m_pq;
  int m_si[6];
  int m_sq[6];
  int m_ph, m_oi, m_oq;
  logic m_valid, m_bi, m_bq;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int sat8(input int x);
    if (x > 127)  return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // One clock edge of the reference model, using pre-edge state.
  task automatic model_edge(input logic rst, input logic r1, input logic r2, input logic en);
    int ai, aq;
    if (rst) begin
      m_pi = 9'h1AA; m_pq = 9'h1FE;
      for (int k = 0; k < 6; k++) begin m_si[k] = 0; m_sq[k] = 0; end
      m_ph = 0; m_oi = 0; m_oq = 0; m_valid = 1'b0; m_bi = 1'b0; m_bq = 1'b0;
    end else begin
      ai = 0; aq = 0;
      for (int k = 0; k < 6; k++) begin
        ai += m_si[k] * h[k*2 + m_ph];
        aq += m_sq[k] * h[k*2 + m_ph];
      end
      m_valid = r2;
      if (r2) begin
        m_oi = sat8(ai);
        m_oq = sat8(aq);
        m_ph = r1 ? 0 : (m_ph + 1) % 2;
      end
      if (r1) begin
        for (int k = 5; k > 0; k--) begin m_si[k] = m_si[k-1]; m_sq[k] = m_sq[k-1]; end
        m_si[0] = en ? (m_pi[8] ? -1 : 1) : 0;
        m_sq[0] = en ? (m_pq[8] ? -1 : 1) : 0;
        if (en) begin
          m_bi = m_pi[8];
          m_bq = m_pq[8];
          m_pi = {m_pi[7:0], m_pi[8] ^ m_pi[4]};
          m_pq = {m_pq[7:0], m_pq[8] ^ m_pq[4]};
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst, input logic r1, input logic r2, input logic en,
                      input bit cmp);
    @(negedge clk);
    i_reset = rst; i_en_rate1 = r1; i_en_rate2 = r2; i_enable_tx = en;
    @(posedge clk);
    model_edge(rst, r1, r2, en);
    if (r2 && !rst) rate2_cnt++;
    #1;
    if (o_valid) valid_cnt++;
    if (cmp) begin
      check("valid", o_valid, m_valid);
      check("data_I", o_os_data_I, m_oi);
      check("data_Q", o_os_data_Q, m_oq);
      check("sym_I", o_sym_I, m_bi);
      check("sym_Q", o_sym_Q, m_bq);
    end
    if (sb_on && o_valid) begin
      if (exp_q.size() == 0) begin
        check("impulse_extra", 1, 0);
      end else begin
        check("impulse_I", o_os_data_I, exp_q[0]);
        check("impulse_Q", o_os_data_Q, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One symbol: two samples, each followed by an idle cycle.
  task automatic symbol(input logic en);
    step(1'b0, 1'b1, 1'b1, en, 1'b1);
    step(1'b0, 1'b0, 1'b0, en, 1'b1);
    step(1'b0, 1'b0, 1'b1, en, 1'b1);
    step(1'b0, 1'b0, 1'b0, en, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    do_reset();
    check("rst_data_I", o_os_data_I, 0);
    check("rst_data_Q", o_os_data_Q, 0);
    check("rst_valid", o_valid, 0);
    check("rst_sym_I", o_sym_I, 0);
    check("rst_sym_Q", o_sym_Q, 0);

    // PRBS order from the seeds, plus saturation on the fixed-sign instances
    for (int i = 0; i < 9; i++) begin
      symbol(1'b1);
      check("prbs_I", o_sym_I, seq_i[i]);
      check("prbs_Q", o_sym_Q, seq_q[i]);
    end
    check("sat_pos_I", sp_I, 127);
    check("sat_pos_Q", sp_Q, 127);
    check("sat_neg_I", sn_I, -128);
    check("sat_neg_Q", sn_Q, -128);

    // Impulse: one -1 symbol, then flush
    do_reset();
    exp_q.push_back(8'sd0);  // symbol-load edge still sees an empty register
    for (int i = 0; i < 12; i++) exp_q.push_back(8'(impulse[i]));
    exp_q.push_back(8'sd0);
    sb_on = 1'b1;
    symbol(1'b1);
    for (int i = 0; i < 6; i++) symbol(1'b0);
    sb_on = 1'b0;
    check("impulse_left", exp_q.size(), 0);

    // Reset in the middle of a symbol, at phase 1, with a sample enable high
    do_reset();
    for (int i = 0; i < 3; i++) symbol(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("mid_rst_data_I", o_os_data_I, 0);
    check("mid_rst_data_Q", o_os_data_Q, 0);
    check("mid_rst_valid", o_valid, 0);
    symbol(1'b1);
    check("post_rst_sym_I", o_sym_I, 1);
    check("post_rst_sym_Q", o_sym_Q, 1);

    // Flush for several symbols, then resume without skipping bits
    do_reset();
    for (int i = 0; i < 9; i++) symbol(1'b1);
    for (int i = 0; i < 7; i++) symbol(1'b0);
    check("flush_data_I", o_os_data_I, 0);
    check("flush_data_Q", o_os_data_Q, 0);
    for (int i = 0; i < 4; i++) begin
      symbol(1'b1);
      check("resume_sym_I", o_sym_I, resume_i[i]);
    end

    // Long run with random idle gaps; period and valid count checks
    do_reset();
    rate2_cnt = 0;
    valid_cnt = 0;
    for (int n = 0; n < 2000; n++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      if (n >= 511 && n < 520) begin
        check("period_I", o_sym_I, seq_i[n-511]);
        check("period_Q", o_sym_Q, seq_q[n-511]);
      end
    end
    check("valid_count", valid_cnt, rate2_cnt);
    check("run_sat_pos", sp_I, 127);
    check("run_sat_neg", sn_Q, -128);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
